div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle controller for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU) in the EX stage of the RV32IM pipeline. The block takes the divide path out of the single-cycle ALU and runs an iterative restoring divider under an FSM. It stalls the pipeline through the hazard unit until the result is ready, then presents the result for one cycle for the EX/MEM register to capture. MUL-family and base-ALU operations never touch this block.

## Interface
- XLEN, 32: operand/result width; the iteration counter is $clog2(XLEN) bits.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- StartE  in  1  valid instruction in EX (not a bubble).
- ALUControlE  in  5  ALU op code from ID/EX; only the four divide codes start the block.
- SrcAE  in  XLEN  dividend (rs1 after forwarding).
- SrcBE  in  XLEN  divisor (rs2 after forwarding).
- FlushE  in  1  EX flush from the hazard unit; aborts any operation.
- StallDivE  out  1  to the hazard unit; holds F/D/E while high (combinational).
- DivDoneE  out  1  one-cycle pulse; DivResultE valid this cycle.
- DivResultE  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, counter 0, internal registers 0, DivResultE = 0, DivDoneE = 0, StallDivE = 0.
- isDiv = ALUControlE in {DIV 10001, DIVU 10101, REM 11001, REMU 11101}.
- IDLE: when StartE & isDiv & ~FlushE:
  - StallDivE = 1 in this cycle.
  - Latch op, |A|, |B|, and sign flags. Magnitudes are used only for the signed ops.
  - Clear the remainder accumulator and load the counter with XLEN-1.
  - Go to CALC, except for the special cases below, which go straight to DONE.
- Special cases, resolved at accept:
  - B == 0: quotient = 0xFFFFFFFF, remainder = A.
  - DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract |B| from rem, using XLEN+1-bit arithmetic.
  - If the result is non-negative, keep it and set quo[0] = 1.
  - Decrement the counter. After the step with counter == 0, go to DONE.
  - StallDivE = 1 throughout.
- DONE: DivDoneE = 1, StallDivE = 0.
  - Sign fix-up: the signed quotient is negated if sign(A) ≠ sign(B); the signed remainder takes the sign of A.
  - DivResultE selects quotient or remainder by the latched op.
  - StartE is ignored. The next state is always IDLE.
- DivResultE holds its last value when not in DONE. Consumers qualify it with DivDoneE.
- FlushE high in any state: next state IDLE, no DivDoneE, StallDivE = 0 in that cycle. FlushE has priority over start.
- reset in any state: IDLE on the next edge, regardless of other inputs.
- A divide instruction arriving in EX in the cycle right after DONE is accepted normally. There is no dead cycle beyond DONE→IDLE.

## Timing
- Accept cycle T, then T+1..T+XLEN are CALC (32 cycles), then T+XLEN+1 is DONE.
- Normal latency is 34 cycles from accept to result, with 33 stall cycles.
- Special cases: accept at T, DONE at T+1. Latency is 2 cycles with 1 stall cycle.
- StallDivE is combinational from state, StartE, ALUControlE and FlushE. It must be high in the accept cycle so the instruction holds in EX.
- StallDivE must drop in DONE so that the EX/MEM edge at the end of DONE captures DivResultE.
- DivDoneE and DivResultE are registered-state outputs with no combinational path from SrcAE/SrcBE.

## Structure
- Shared package (alu_pkg):
  - ALU op-code localparams, shared with the ALU and the control unit.
  - Divider state enum (IDLE/CALC/DONE).
  - Special-case constants (INT_MIN, all-ones).
- One sub-module, div_step: combinational single restoring-division step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - This isolates the datapath so the FSM file holds only sequencing.

## Test plan
- DIVU 100 / 7: accept at T; stall high T..T+32; at T+33 DivDoneE = 1 and DivResultE = 14. REMU with the same operands → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3); REM −7 / 2 → 0xFFFFFFFF (−1); REM 7 / −2 → 1.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF at T+1; REMU 5 / 0 → 5; exactly one stall cycle.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1; REM with the same operands → 0.
- FlushE at T+10 of a DIVU: state returns to IDLE, no DivDoneE, StallDivE low. A new DIVU 9 / 3 accepted two cycles later yields 3 at accept+33.
- reset asserted mid-CALC: all outputs 0 the next cycle. Back-to-back DIVU issued with no gap after DONE: second result correct at DONE+1+33.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, divider FSM states and the constants
// used by the divide special cases.
package alu_pkg;
    localparam int XLEN = 32;

    localparam logic [4:0] ALU_DIV  = 5'b10001;
    localparam logic [4:0] ALU_DIVU = 5'b10101;
    localparam logic [4:0] ALU_REM  = 5'b11001;
    localparam logic [4:0] ALU_REMU = 5'b11101;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction
endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage divide handshake: pipeline side (master) and divider side (slave).
interface div_sequencer_if #(parameter int XLEN = alu_pkg::XLEN);
    logic            StartE;
    logic [4:0]      ALUControlE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallDivE;
    logic            DivDoneE;
    logic [XLEN-1:0] DivResultE;

    modport master (output StartE, ALUControlE, SrcAE, SrcBE, FlushE,
                    input  StallDivE, DivDoneE, DivResultE);
    modport slave  (input  StartE, ALUControlE, SrcAE, SrcBE, FlushE,
                    output StallDivE, DivDoneE, DivResultE);
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits
    // and the top bit of the trial difference is a valid sign.
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        quo_next = {quo[XLEN-2:0], ~trial[XLEN]};
        rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller for EX: stalls the pipe while an
// iterative restoring divide runs, then presents the result for one cycle.
module div_sequencer
    import alu_pkg::*;
(
    input logic           clk,
    input logic           reset,
    div_sequencer_if.slave dif
);
    localparam int CW = $clog2(XLEN);

    div_state_t      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
    logic            is_rem_q, neg_quo_q, neg_rem_q;

    logic            start, sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, rem_n, quo_n, quo_fix, rem_fix;

    assign start = dif.StartE && is_div_op(dif.ALUControlE) && !dif.FlushE;
    assign sgn   = !dif.ALUControlE[2];
    assign a_neg = sgn && dif.SrcAE[XLEN-1];
    assign b_neg = sgn && dif.SrcBE[XLEN-1];
    assign a_mag = a_neg ? -dif.SrcAE : dif.SrcAE;
    assign b_mag = b_neg ? -dif.SrcBE : dif.SrcBE;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    assign quo_fix = neg_quo_q ? -quo_n : quo_n;
    assign rem_fix = neg_rem_q ? -rem_n : rem_n;

    // Stall must cover the accept cycle so the instruction stays in EX.
    assign dif.StallDivE  = !dif.FlushE && ((state == IDLE && start) || state == CALC);
    assign dif.DivDoneE   = (state == DONE) && !dif.FlushE;
    assign dif.DivResultE = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (dif.FlushE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    is_rem_q  <= dif.ALUControlE[3];
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    dvsr_q    <= b_mag;
                    quo_q     <= a_mag;
                    rem_q     <= '0;
                    cnt       <= CW'(XLEN - 1);
                    if (dif.SrcBE == '0) begin
                        result_q <= dif.ALUControlE[3] ? dif.SrcAE : ALL_ONES;
                        state    <= DONE;
                    end else if (sgn && dif.SrcAE == INT_MIN && dif.SrcBE == ALL_ONES) begin
                        result_q <= dif.ALUControlE[3] ? '0 : INT_MIN;
                        state    <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_q <= is_rem_q ? rem_fix : quo_fix;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: expected results queued at accept and
// checked when DivDoneE appears, along with stall and latency timing.
module tb_div_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    div_sequencer_if dif ();

    div_sequencer dut (.clk(clk), .reset(reset), .dif(dif));

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one op, then follow it to DONE checking stall count and latency.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int stalls;
        logic [31:0] want;
        @(negedge clk);
        dif.StartE = 1'b1; dif.ALUControlE = op; dif.SrcAE = a; dif.SrcBE = b;
        sb.push_back(exp);
        #1 chk({tag, "/stall_accept"}, dif.StallDivE, 1);
        stalls = 1;
        @(negedge clk);
        dif.StartE = 1'b0; dif.ALUControlE = 5'b0; dif.SrcAE = $urandom; dif.SrcBE = $urandom;
        cyc = 1;
        #1;
        while (!dif.DivDoneE && cyc < 100) begin
            if (dif.StallDivE) stalls++;
            @(negedge clk);
            #1 cyc++;
        end
        chk({tag, "/done_seen"}, dif.DivDoneE, 1);
        chk({tag, "/latency"}, cyc, lat);
        chk({tag, "/stall_cycles"}, stalls, lat);
        chk({tag, "/stall_in_done"}, dif.StallDivE, 0);
        if (dif.DivDoneE && sb.size() > 0) begin
            want = sb.pop_front();
            chk({tag, "/result"}, dif.DivResultE, want);
        end
    endtask

    // Accept an op whose result will never be delivered (flush / reset cases).
    task automatic accept_only(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.StartE = 1'b1; dif.ALUControlE = op; dif.SrcAE = a; dif.SrcBE = b;
        #1 chk("abort/stall_accept", dif.StallDivE, 1);
        @(negedge clk);
        dif.StartE = 1'b0; dif.ALUControlE = 5'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        dif.StartE = 1'b0; dif.ALUControlE = 5'b0; dif.SrcAE = '0; dif.SrcBE = '0; dif.FlushE = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset/done", dif.DivDoneE, 0);
        chk("reset/stall", dif.StallDivE, 0);
        chk("reset/result", dif.DivResultE, 0);
        reset = 1'b0;

        run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        @(negedge clk);
        #1 chk("hold/done_low", dif.DivDoneE, 0);
        chk("hold/result", dif.DivResultE, 32'd14);
        run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("div_100_m7", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        run_op("divu_big_3", ALU_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33);
        run_op("div_min_2", ALU_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

        run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Flush at accept+10, then a fresh op two cycles later.
        accept_only(ALU_DIVU, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        dif.FlushE = 1'b1;
        #1 chk("flush/stall", dif.StallDivE, 0);
        chk("flush/done", dif.DivDoneE, 0);
        @(negedge clk);
        dif.FlushE = 1'b0;
        #1 chk("flush/idle_stall", dif.StallDivE, 0);
        chk("flush/idle_done", dif.DivDoneE, 0);
        run_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Reset mid-CALC clears everything, including the held result.
        accept_only(ALU_DIVU, 32'd50, 32'd5);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 chk("rst_calc/done", dif.DivDoneE, 0);
        chk("rst_calc/stall", dif.StallDivE, 0);
        chk("rst_calc/result", dif.DivResultE, 0);
        reset = 1'b0;

        run_op("b2b_first", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("b2b_second", ALU_DIVU, 32'd1000, 32'd10, 32'd100, 33);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
